// File: rtl/keycode_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : keycode_event_queue
// Description : Turns the keycode level driven by the processor-side PIO into
//               discrete key events. A new nonzero keycode produces a press
//               event. Holding the key produces typematic repeat events, the
//               first after REPEAT_DELAY cycles and then one every
//               REPEAT_RATE cycles. Events are buffered in a small FIFO that
//               a valid/ready consumer drains.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH          FIFO entries (power of 2, >= 2)
//   REPEAT_DELAY   cycles from press event to first repeat event (>= 2)
//   REPEAT_RATE    cycles between subsequent repeat events (>= 2)
// Ports
//   clk             in   1   system clock, rising edge
//   reset           in   1   synchronous, active-high reset
//   keycode_in      in   8   keycode level, 0x00 = no key
//   evt_ready       in   1   consumer accepts the head event
//   clear_overflow  in   1   single-cycle clear of overflow
//   evt_valid       out  1   FIFO non-empty
//   evt_code        out  8   keycode of the head event (0 when empty)
//   evt_repeat      out  1   head event is a typematic repeat (0 when empty)
//   overflow        out  1   sticky: an event was dropped on a full FIFO
//   count           out  log2(DEPTH)+1   FIFO occupancy
// ============================================================================
module keycode_event_queue #(
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               keycode_in,
    input  logic                     evt_ready,
    input  logic                     clear_overflow,
    output logic                     evt_valid,
    output logic [7:0]               evt_code,
    output logic                     evt_repeat,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_aw   = $clog2(DEPTH);
    localparam int c_cmax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_cw   = $clog2(c_cmax);

    localparam logic [c_cw-1:0] c_delay_last = c_cw'(REPEAT_DELAY - 1);
    localparam logic [c_cw-1:0] c_rate_last  = c_cw'(REPEAT_RATE - 1);
    localparam logic [c_aw:0]   c_depth      = (c_aw + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [7:0]      r_kc_q;
    logic [7:0]      r_kc_prev;
    state_t          r_state;
    logic [c_cw-1:0] r_cnt;

    logic [8:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic [8:0]      r_head;
    logic            r_overflow;

    // ------------------------------------------------------------------------
    // Combinational event and FIFO control
    // ------------------------------------------------------------------------
    logic            w_press;
    logic            w_expire;
    logic            w_event;
    logic [8:0]      w_evt_data;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic [c_aw-1:0] w_rd_next;
    logic [c_aw:0]   w_count_next;
    logic [c_aw:0]   w_remaining;
    logic [8:0]      w_head_next;

    assign w_press = (r_kc_q != 8'h00) && (r_kc_q != r_kc_prev);

    assign w_expire = ((r_state == S_DELAY)  && (r_cnt == c_delay_last)) ||
                      ((r_state == S_REPEAT) && (r_cnt == c_rate_last));

    // A release in the same cycle as an expiry suppresses the repeat; a press
    // in the same cycle wins and is tagged as a fresh press.
    assign w_event    = w_press || (w_expire && (r_kc_q != 8'h00));
    assign w_evt_data = {~w_press, r_kc_q};

    assign w_pop  = (r_count != '0) && evt_ready;
    assign w_push = w_event && ((r_count < c_depth) || w_pop);
    assign w_drop = w_event && !w_push;

    assign w_rd_next   = w_pop ? (r_rd_ptr + c_aw'(1)) : r_rd_ptr;
    assign w_remaining = w_pop ? (r_count - (c_aw + 1)'(1)) : r_count;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + (c_aw + 1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - (c_aw + 1)'(1);
        end
    end

    // The head register reflects the FIFO as it will be after this edge. When
    // no older entry survives the pop, the new head is the entry being written
    // this cycle, which is not yet readable from the memory array.
    always_comb begin
        w_head_next = 9'h000;
        if (w_count_next != '0) begin
            if (w_remaining == '0) begin
                w_head_next = w_evt_data;
            end else begin
                w_head_next = r_mem[w_rd_next];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Input stage: keycode level and its one-cycle-old copy
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kc_q    <= 8'h00;
            r_kc_prev <= 8'h00;
        end else begin
            r_kc_q    <= keycode_in;
            r_kc_prev <= r_kc_q;
        end
    end

    // ------------------------------------------------------------------------
    // Hold FSM: delay and repeat timing for the currently held key
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (w_press) begin
            r_state <= S_DELAY;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                end
                S_DELAY: begin
                    if (r_kc_q == 8'h00) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_delay_last) begin
                        r_state <= S_REPEAT;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                S_REPEAT: begin
                    if (r_kc_q == 8'h00) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_rate_last) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage (contents are don't-care until written)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_evt_data;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers, occupancy, head register and overflow flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_head     <= 9'h000;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_head   <= w_head_next;
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign evt_valid  = (r_count != '0);
    assign evt_code   = r_head[7:0];
    assign evt_repeat = r_head[8];
    assign overflow   = r_overflow;
    assign count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_keycode_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_keycode_event_queue
// Description : Self-checking bench for keycode_event_queue. A reference model
//               predicts key events from the input history (press = new
//               nonzero key, repeats at fixed offsets from the press) and the
//               resulting FIFO occupancy; expected events go to a scoreboard
//               that an independent monitor pops on each observed transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keycode_event_queue;

    localparam int DEPTH        = 4;
    localparam int REPEAT_DELAY = 10;
    localparam int REPEAT_RATE  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] keycode_in;
    logic       evt_ready;
    logic       clear_overflow;
    logic       evt_valid;
    logic [7:0] evt_code;
    logic       evt_repeat;
    logic       overflow;
    logic [2:0] count;

    keycode_event_queue #(
        .DEPTH        (DEPTH),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .keycode_in     (keycode_in),
        .evt_ready      (evt_ready),
        .clear_overflow (clear_overflow),
        .evt_valid      (evt_valid),
        .evt_code       (evt_code),
        .evt_repeat     (evt_repeat),
        .overflow       (overflow),
        .count          (count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model (evaluated at each rising edge on stable inputs)
    // ------------------------------------------------------------------------
    logic [8:0] sb[$];        // expected events, in order, awaiting transfer
    int         m_count = 0;  // expected occupancy
    bit         m_ovf   = 0;
    logic [7:0] h1 = 8'h00;   // keycode sampled at the previous edge
    logic [7:0] h2 = 8'h00;   // keycode sampled two edges ago
    bit         m_held = 0;
    int         m_p = 0;      // edge index of the latest press event
    int         m_t = 0;      // edge index

    always @(posedge clk) begin
        bit ev, rep, pop, push;
        int e;
        if (reset) begin
            h1 = 8'h00; h2 = 8'h00; m_held = 0;
            m_count = 0; m_ovf = 0;
            sb.delete();
        end else begin
            ev = 0; rep = 0;
            if (h1 != 8'h00 && h1 != h2) begin
                ev = 1; m_held = 1; m_p = m_t;
            end else if (h1 != 8'h00 && m_held) begin
                e = m_t - m_p;
                if (e == REPEAT_DELAY ||
                    (e > REPEAT_DELAY && (e - REPEAT_DELAY) % REPEAT_RATE == 0)) begin
                    ev = 1; rep = 1;
                end
            end else if (h1 == 8'h00) begin
                m_held = 0;
            end
            pop  = (m_count != 0) && evt_ready;
            push = ev && (m_count < DEPTH || pop);
            m_count = m_count + int'(push) - int'(pop);
            if (push) sb.push_back({rep, h1});
            if (ev && !push) m_ovf = 1;
            else if (clear_overflow) m_ovf = 0;
            h2 = h1;
            h1 = keycode_in;
        end
        m_t++;
    end

    // ------------------------------------------------------------------------
    // Monitor: compares DUT state between edges, pops scoreboard on transfer
    // ------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            check("count", int'(count), m_count);
            check("evt_valid", int'(evt_valid), int'(m_count != 0));
            check("overflow", int'(overflow), int'(m_ovf));
            if (sb.size() > 0) begin
                check("head_code", int'(evt_code), int'(sb[0][7:0]));
                check("head_repeat", int'(evt_repeat), int'(sb[0][8]));
            end else begin
                check("empty_head", int'({evt_repeat, evt_code}), 0);
            end
            if (!reset && evt_valid && evt_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", int'({evt_repeat, evt_code}), -1);
                end else begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [7:0] key, input int n);
        keycode_in = key;
        step(n);
    endtask

    task automatic hold_rand(input logic [7:0] key, input int n);
        keycode_in = key;
        repeat (n) begin
            evt_ready      = ($urandom_range(0, 3) != 0);
            clear_overflow = ($urandom_range(0, 15) == 0);
            step(1);
        end
        clear_overflow = 1'b0;
    endtask

    initial begin
        reset = 1'b1; keycode_in = 8'h2C; evt_ready = 1'b0; clear_overflow = 1'b0;

        // Reset with a key held, then release reset: one fresh press.
        step(2);
        reset = 1'b0;
        hold(8'h2C, 4);
        evt_ready = 1'b1;
        hold(8'h00, 4);

        // Single tap.
        hold(8'h04, 3);
        hold(8'h00, 6);

        // Typematic hold.
        hold(8'h1A, 25);
        hold(8'h00, 8);

        // Overflow with consumer stalled, drain, then clear.
        evt_ready = 1'b0;
        for (int k = 4; k <= 8; k++) hold(8'(k), 2);
        hold(8'h00, 3);
        evt_ready = 1'b1;
        step(6);
        evt_ready = 1'b0;
        clear_overflow = 1'b1;
        step(1);
        clear_overflow = 1'b0;
        step(1);

        // Full FIFO with simultaneous push and pop.
        for (int k = 1; k <= 4; k++) hold(8'(k), 2);
        hold(8'h00, 3);
        keycode_in = 8'h09;
        step(1);
        evt_ready = 1'b1;
        step(1);
        hold(8'h00, 8);

        // Key change while repeating.
        hold(8'h1A, 16);
        hold(8'h1B, 15);
        hold(8'h00, 6);

        // Randomized holds, stalls, clears and occasional resets.
        for (int i = 0; i < 250; i++) begin
            int      k;
            logic [7:0] key;
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                step($urandom_range(1, 2));
                reset = 1'b0;
            end
            k   = $urandom_range(0, 4);
            key = (k == 0) ? 8'h00 : 8'(8'h10 + k);
            hold_rand(key, $urandom_range(1, 20));
        end

        evt_ready = 1'b1;
        hold(8'h00, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
